// File: rtl/serial_tx_pkg.sv
// Shared types and helpers for the serial frame transmitter: line mode,
// parity selection, FSM state encoding and the parity-bit function.
package serial_tx_pkg;

  typedef enum logic {
    UART = 1'b0,
    PS2  = 1'b1
  } mode_t;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    EVEN = 2'd1,
    ODD  = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    IDLE,
    BIT,
    SETUP,
    LOW,
    HIGH,
    GAP
  } state_t;

  localparam int PS2_FRAME_BITS = 11;

  // Unused upper bits must be zero so they do not disturb the reduction.
  function automatic logic parity_bit(input logic [8:0] d, input parity_t p);
    case (p)
      EVEN:    return ^d;
      ODD:     return ~^d;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/serial_tx_fifo.sv
// Synchronous word queue with registered occupancy; a push while full is
// dropped even when a pop happens in the same cycle.
module serial_tx_fifo
  import serial_tx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LVL_W-1:0] level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0]    PTR_ONE   = AW'(1);
  localparam logic [LVL_W-1:0] LVL_ONE   = LVL_W'(1);
  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("serial_tx_fifo: DEPTH must be a power of two >= 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [LVL_W-1:0] count;
  logic             push_ok, pop_ok;

  assign full_o    = (count == LVL_FULL);
  assign empty_o   = (count == '0);
  assign level_o   = count;
  assign rd_data_o = mem[rd_ptr];
  assign push_ok   = push_i && !full_o;
  assign pop_ok    = pop_i && !empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + LVL_ONE;
        2'b01:   count <= count - LVL_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; only pointers and occupancy define contents.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr] <= wr_data_i;
  end

endmodule

// File: rtl/serial_frame_tx.sv
// Replays queued words as UART frames or PS/2 device-to-host frames.
// Every line output is a register; the FSM owns all bit timing.
module serial_frame_tx
  import serial_tx_pkg::*;
#(
  parameter int CLK_HZ           = 100_000_000,
  parameter int DATA_BITS        = 8,
  parameter int FIFO_DEPTH       = 16,
  parameter int UART_BIT_CYCLES  = 868,
  parameter int UART_PARITY      = 0,
  parameter int UART_STOP_BITS   = 1,
  parameter int PS2_SETUP_CYCLES = 20,
  parameter int PS2_LOW_CYCLES   = 100,
  parameter int PS2_HIGH_CYCLES  = 80,
  parameter int GAP_CYCLES       = 0
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            mode_i,
  input  logic [DATA_BITS-1:0]            data_i,
  input  logic                            valid_i,
  output logic                            ready_o,
  output logic                            txd_o,
  output logic                            ps2_clk_o,
  output logic                            busy_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] level_o
);

  localparam int LVL_W       = $clog2(FIFO_DEPTH + 1);
  localparam int UART_PAR_N  = (UART_PARITY != 0) ? 1 : 0;
  localparam int UART_BITS   = 1 + DATA_BITS + UART_PAR_N + UART_STOP_BITS;
  localparam int SH_W        = (UART_BITS > PS2_FRAME_BITS) ? UART_BITS : PS2_FRAME_BITS;
  localparam int CNT_W       = $clog2(SH_W);
  localparam int T_A         = (UART_BIT_CYCLES > GAP_CYCLES) ? UART_BIT_CYCLES : GAP_CYCLES;
  localparam int T_B         = (PS2_LOW_CYCLES > PS2_HIGH_CYCLES) ? PS2_LOW_CYCLES : PS2_HIGH_CYCLES;
  localparam int T_C         = (T_B > PS2_SETUP_CYCLES) ? T_B : PS2_SETUP_CYCLES;
  localparam int TMR_MAX     = (T_A > T_C) ? T_A : T_C;
  localparam int TMR_W       = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(1);
  localparam logic [TMR_W-1:0] UART_LOAD  = TMR_W'(UART_BIT_CYCLES - 1);
  localparam logic [TMR_W-1:0] SETUP_LOAD = TMR_W'(PS2_SETUP_CYCLES - 1);
  localparam logic [TMR_W-1:0] LOW_LOAD   = TMR_W'(PS2_LOW_CYCLES - 1);
  localparam logic [TMR_W-1:0] HIGH_LOAD  = TMR_W'(PS2_HIGH_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD   = TMR_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] UART_LAST  = CNT_W'(UART_BITS - 1);
  localparam logic [CNT_W-1:0] PS2_LAST   = CNT_W'(PS2_FRAME_BITS - 1);
  localparam parity_t          UART_PAR   = parity_t'(UART_PARITY[1:0]);
  localparam state_t           END_STATE  = (GAP_CYCLES > 0) ? GAP : IDLE;

  if (DATA_BITS < 5 || DATA_BITS > 9 || CLK_HZ <= 0) begin : g_param_check
    $error("serial_frame_tx: DATA_BITS must be 5..9 and CLK_HZ positive");
  end

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [SH_W-1:0]    shreg_q, shreg_d;
  logic               txd_q, txd_d;
  logic               ps2_clk_q, ps2_clk_d;
  logic               busy_q;
  logic               pop;
  logic               fifo_full, fifo_empty;
  logic [DATA_BITS-1:0] fifo_rd_data;
  logic [8:0]         data_ext;
  logic [SH_W-1:0]    uart_frame, ps2_frame;

  serial_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push_i    (valid_i),
    .wr_data_i (data_i),
    .pop_i     (pop),
    .rd_data_o (fifo_rd_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .level_o   (level_o)
  );

  assign ready_o   = !fifo_full;
  assign txd_o     = txd_q;
  assign ps2_clk_o = ps2_clk_q;
  assign busy_o    = busy_q;

  // Frames are built LSB-first; idle-high filler above the last bit.
  always_comb begin
    data_ext = '0;
    data_ext[DATA_BITS-1:0] = fifo_rd_data;
    uart_frame = '1;
    uart_frame[0] = 1'b0;
    uart_frame[DATA_BITS:1] = fifo_rd_data;
    if (UART_PAR_N != 0) uart_frame[DATA_BITS+1] = parity_bit(data_ext, UART_PAR);
    ps2_frame = '1;
    ps2_frame[0] = 1'b0;
    ps2_frame[8:1] = data_ext[7:0];
    ps2_frame[9] = parity_bit({1'b0, data_ext[7:0]}, ODD);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (!fifo_empty) state_d = (mode_t'(mode_i) == PS2) ? SETUP : BIT;
      BIT:   if (tmr_q == '0 && bit_cnt_q == '0) state_d = END_STATE;
      SETUP: if (tmr_q == '0) state_d = LOW;
      LOW:   if (tmr_q == '0) state_d = HIGH;
      HIGH:  if (tmr_q == '0) state_d = (bit_cnt_q == '0) ? END_STATE : SETUP;
      GAP:   if (tmr_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pop       = 1'b0;
    tmr_d     = tmr_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    txd_d     = txd_q;
    ps2_clk_d = ps2_clk_q;
    case (state_q)
      IDLE: begin
        txd_d     = 1'b1;
        ps2_clk_d = 1'b1;
        if (!fifo_empty) begin
          pop = 1'b1;
          if (mode_t'(mode_i) == PS2) begin
            shreg_d   = ps2_frame;
            bit_cnt_d = PS2_LAST;
            tmr_d     = SETUP_LOAD;
            txd_d     = ps2_frame[0];
          end else begin
            shreg_d   = uart_frame;
            bit_cnt_d = UART_LAST;
            tmr_d     = UART_LOAD;
            txd_d     = uart_frame[0];
          end
        end
      end
      BIT, HIGH: begin
        // Bit boundary: UART moves to the next bit, PS/2 to the next setup.
        if (tmr_q != '0) begin
          tmr_d = tmr_q - TMR_ONE;
        end else if (bit_cnt_q == '0) begin
          txd_d     = 1'b1;
          ps2_clk_d = 1'b1;
          tmr_d     = GAP_LOAD;
        end else begin
          shreg_d   = shreg_q >> 1;
          txd_d     = shreg_q[1];
          bit_cnt_d = bit_cnt_q - CNT_ONE;
          tmr_d     = (state_q == BIT) ? UART_LOAD : SETUP_LOAD;
        end
      end
      SETUP: begin
        if (tmr_q != '0) tmr_d = tmr_q - TMR_ONE;
        else begin
          ps2_clk_d = 1'b0;
          tmr_d     = LOW_LOAD;
        end
      end
      LOW: begin
        if (tmr_q != '0) tmr_d = tmr_q - TMR_ONE;
        else begin
          ps2_clk_d = 1'b1;
          tmr_d     = HIGH_LOAD;
        end
      end
      GAP: begin
        txd_d     = 1'b1;
        ps2_clk_d = 1'b1;
        if (tmr_q != '0) tmr_d = tmr_q - TMR_ONE;
      end
      default: begin
        txd_d     = 1'b1;
        ps2_clk_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmr_q     <= '0;
      bit_cnt_q <= '0;
      txd_q     <= 1'b1;
      ps2_clk_q <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      tmr_q     <= tmr_d;
      bit_cnt_q <= bit_cnt_d;
      txd_q     <= txd_d;
      ps2_clk_q <= ps2_clk_d;
      busy_q    <= (state_d != IDLE);
    end
  end

  always_ff @(posedge clk_i) begin
    shreg_q <= shreg_d;
  end

endmodule

// File: doc/serial_frame_tx.md
# serial_frame_tx

Parametrised, synthesizable serial frame transmitter that replays byte streams onto either a UART TX line or a PS/2 device-to-host clock/data pair. It feeds the board's `uart_rxd_i` and `ps2_clk_i`/`ps2_data_i` inputs in hardware loopback and in self-checking benches. Words are queued in an internal FIFO and transmitted with configurable bit timing, parity, stop bits and inter-frame gap.

## Interface
- `CLK_HZ`, 100_000_000: clock frequency; documentation only, all timing is in cycles.
- `DATA_BITS`, 8: UART data bits (5..9); PS/2 mode always sends `data[7:0]`.
- `FIFO_DEPTH`, 16: queue depth; power of two, ≥2.
- `UART_BIT_CYCLES`, 868: cycles per UART bit (115200 baud at 100 MHz).
- `UART_PARITY`, 0: 0 none, 1 even, 2 odd.
- `UART_STOP_BITS`, 1: 1 or 2.
- `PS2_SETUP_CYCLES`, 20: data-valid to clock-fall.
- `PS2_LOW_CYCLES`, 100: clock-low time.
- `PS2_HIGH_CYCLES`, 80: clock-high time after rise.
- `GAP_CYCLES`, 0: idle cycles after each frame.

Ports:
- `clk_i`  in  1  system clock.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `mode_i`  in  1  0 UART, 1 PS/2; sampled at frame load.
- `data_i`  in  DATA_BITS  word to queue.
- `valid_i`  in  1  push request.
- `ready_o`  out  1  FIFO not full; push accepted on `valid_i && ready_o`.
- `txd_o`  out  1  UART TX line / PS/2 data line.
- `ps2_clk_o`  out  1  PS/2 clock (held high in UART mode).
- `busy_o`  out  1  frame in progress (any non-IDLE state).
- `level_o`  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy.

## Operation
- Reset values: `txd_o`=1, `ps2_clk_o`=1, `busy_o`=0, `level_o`=0, `ready_o`=1; FIFO flushed, FSM in IDLE.
- FSM: IDLE → (UART) BIT → GAP → IDLE; IDLE → (PS/2) SETUP → LOW → HIGH → … → GAP → IDLE.
- IDLE: FIFO non-empty → pop, latch mode, build frame shift register, load bit counter, drive first bit.
- UART frame, LSB first: start 0, DATA_BITS data, optional parity (even = ^data, odd = ~^data), UART_STOP_BITS × 1. Each bit held UART_BIT_CYCLES in BIT.
- PS/2 frame, 11 bits LSB first: 0, data[7:0], odd parity (~^data), 1. Per bit: SETUP drives `txd_o`, LOW drives `ps2_clk_o`=0, HIGH drives `ps2_clk_o`=1; after HIGH, advance to next bit's SETUP, or GAP after bit 10.
- GAP: lines high for GAP_CYCLES; GAP_CYCLES=0 skips directly to IDLE.
- `mode_i` changes mid-frame take effect at the next frame.
- Push while full: dropped, no state change, even if a pop occurs the same cycle.
- Reset mid-frame: lines return high asynchronously, queued words discarded.

## Timing
- All outputs registered; no combinational input→output path except `ready_o` (from registered FIFO state only).
- Push accepted at edge k into an empty, idle block: popped at edge k+1; first bit on `txd_o` after edge k+1.
- UART frame length: (1+DATA_BITS+(parity≠0)+UART_STOP_BITS)·UART_BIT_CYCLES; default 8680 cycles.
- PS/2 bit period: SETUP+LOW+HIGH = 200 cycles; frame 2200 cycles; `txd_o` stable across each full clock-low window.
- Back-to-back frames: next start bit follows last stop/HIGH cycle after exactly GAP_CYCLES + 1 cycles (one IDLE cycle).
- Counters count down from N−1 to 0; terminal count triggers the transition.
- `level_o` updates on the edge after push/pop; simultaneous push and pop leave it unchanged.

## Structure
- `serial_tx_pkg`: `mode_t` (UART, PS2), `parity_t` (NONE, EVEN, ODD), `state_t` (IDLE, BIT, SETUP, LOW, HIGH, GAP), parity function.
- Sub-module `serial_tx_fifo`: synchronous FIFO with full/empty/level, async active-low reset; the FSM and shifter stay in `serial_frame_tx`.

## Test plan
- UART 8N1 defaults, push 0x33 → `txd_o` 0 for 868 cycles, then 1,1,0,0,1,1,0,0, then stop 1; frame = 8680 cycles, `busy_o` high throughout.
- PS/2 mode, push 0x29 → 11 falls on `ps2_clk_o` with 200-cycle spacing; `txd_o` sampled at falls = 0,1,0,0,1,0,1,0,0,0(parity),1.
- UART_PARITY=1, UART_STOP_BITS=2, push 0x4B → parity bit 0, two stop bits; frame 12·868 = 10416 cycles.
- `valid_i` held 20 cycles from idle → 17 accepted (1 in flight + 16), `ready_o`=0 from 17th accepted push, `level_o`=16; all 17 words transmit in order.
- Push 0x24 (UART), then 0xF0 (PS/2) with GAP_CYCLES=50 → start of the second frame lands 51 cycles after the first stop bit ends; mode switches at frame boundary only.
- Assert `rst_ni` low mid-data-bit with 3 words queued → `txd_o`/`ps2_clk_o` high immediately, `level_o`=0, no further frames after release.
